// File: rtl/demod_audio_post_pkg.sv
// Shared definitions for the demodulator audio post-processor: mode codes,
// squelch states and the output range classifier.
package demod_audio_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FM   = 2'd0;
    localparam mode_t MODE_PM   = 2'd1;
    localparam mode_t MODE_AM   = 2'd2;
    localparam mode_t MODE_MUTE = 2'd3;

    typedef enum logic [1:0] {
        SQ_CLOSED = 2'd0,
        SQ_OPEN   = 2'd1,
        SQ_HANG   = 2'd2
    } sq_state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_e;

    // Classifies v against the signed w-bit range; the caller substitutes the rail value.
    function automatic sat_e saturate(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 32'd1));
        if (v > hi) begin
            saturate = SAT_HI;
        end else if (v < lo) begin
            saturate = SAT_LO;
        end else begin
            saturate = SAT_NONE;
        end
    endfunction

endpackage

// File: rtl/demod_audio_post_if.sv
// Sample/audio bus between the demodulator, the audio post-processor and the codec side.
interface demod_audio_post_if
    import demod_audio_pkg::*;
#(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 12
);
    logic                        sample_en;
    mode_t                       mode;
    logic        [IN_WIDTH-1:0]  sq_thresh;
    logic        [IN_WIDTH-1:0]  FM_in;
    logic        [IN_WIDTH-1:0]  PM_in;
    logic        [IN_WIDTH-1:0]  AM_in;
    logic signed [OUT_WIDTH-1:0] audio_out;
    logic                        audio_valid;
    logic                        squelch_open;

    modport master (
        output sample_en, mode, sq_thresh, FM_in, PM_in, AM_in,
        input  audio_out, audio_valid, squelch_open
    );

    modport slave (
        input  sample_en, mode, sq_thresh, FM_in, PM_in, AM_in,
        output audio_out, audio_valid, squelch_open
    );
endinterface

// File: rtl/demod_audio_post_dc_blocker.sv
// Leaky-integrator DC tracker: acc follows 2^DC_SHIFT times the input mean,
// y is the input with that mean removed.
module dc_blocker #(
    parameter int IN_WIDTH = 12,
    parameter int DC_SHIFT = 8
) (
    input  logic                       clk_in,
    input  logic                       RST,
    input  logic                       en,
    input  logic signed [IN_WIDTH:0]   x,
    output logic signed [IN_WIDTH+1:0] y
);
    localparam int AW = IN_WIDTH + 1 + DC_SHIFT;
    localparam int YW = IN_WIDTH + 2;

    logic signed [AW-1:0]     acc_q;
    logic signed [AW-1:0]     acc_d;
    logic signed [IN_WIDTH:0] dc_s;

    // The upper slice of acc is the floor-divided DC estimate.
    always_comb begin
        dc_s  = acc_q[AW-1:DC_SHIFT];
        y     = {x[IN_WIDTH], x} - {dc_s[IN_WIDTH], dc_s};
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + {{(DC_SHIFT - 1){y[YW-1]}}, y};
        end else begin
            acc_d = acc_q;
        end
    end

    // Integrator state register.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            acc_q <= {AW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/demod_audio_post.sv
// Audio post-processor: source select, DC removal, accumulate-and-dump
// decimation and carrier squelch with hang time.
module demod_audio_post
    import demod_audio_pkg::*;
#(
    parameter int IN_WIDTH   = 12,
    parameter int OUT_WIDTH  = 12,
    parameter int DECIM_LOG2 = 3,
    parameter int DC_SHIFT   = 8,
    parameter int SQ_HOLD    = 16
) (
    input  logic              clk_in,
    input  logic              RST,
    demod_audio_post_if.slave bus
);
    localparam int XW = IN_WIDTH + 1;
    localparam int YW = IN_WIDTH + 2;
    localparam int SW = YW + DECIM_LOG2;
    localparam int MW = IN_WIDTH + DECIM_LOG2;
    localparam int HW = $clog2(SQ_HOLD + 1);

    localparam logic [DECIM_LOG2-1:0] CNT_ZERO  = {DECIM_LOG2{1'b0}};
    localparam logic [DECIM_LOG2-1:0] CNT_LAST  = {DECIM_LOG2{1'b1}};
    localparam logic [DECIM_LOG2-1:0] CNT_ONE   = DECIM_LOG2'(1);
    localparam logic [HW-1:0]         HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]         HOLD_LOAD = HW'(SQ_HOLD - 1);
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
    mode_t                  mode_q, mode_d;
    mode_t                  mode_eff_s;
    logic signed [XW-1:0]   x_s;
    logic signed [YW-1:0]   y_s;
    logic signed [SW-1:0]   asum_q, asum_d;
    logic signed [SW-1:0]   total_s;
    logic [MW-1:0]          msum_q, msum_d;
    logic [MW-1:0]          mtotal_s;
    logic [IN_WIDTH-1:0]    mean_s;
    logic                   level_ok_s;
    logic                   frame_start_s;
    logic                   frame_end_s;
    logic signed [31:0]     q_wide_s;
    logic signed [OUT_WIDTH-1:0] q_sat_s;
    sq_state_e              sq_state_q, sq_state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic signed [OUT_WIDTH-1:0] audio_out_q, audio_out_d;
    logic                   audio_valid_q, audio_valid_d;
    logic                   sq_open_q, sq_open_d;

    assign frame_start_s = bus.sample_en && (cnt_q == CNT_ZERO);
    assign frame_end_s   = bus.sample_en && (cnt_q == CNT_LAST);
    // The first sample of a frame already uses the mode being latched for it.
    assign mode_eff_s    = (cnt_q == CNT_ZERO) ? bus.mode : mode_q;

    // Source select on the frame's mode.
    always_comb begin
        case (mode_eff_s)
            MODE_FM: x_s = {bus.FM_in[IN_WIDTH-1], bus.FM_in};
            MODE_PM: x_s = {bus.PM_in[IN_WIDTH-1], bus.PM_in};
            MODE_AM: x_s = {1'b0, bus.AM_in};
            default: x_s = {XW{1'b0}};
        endcase
    end

    dc_blocker #(
        .IN_WIDTH (IN_WIDTH),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk_in (clk_in),
        .RST    (RST),
        .en     (bus.sample_en),
        .x      (x_s),
        .y      (y_s)
    );

    // Frame accumulators, frame counter and mode latch next-state.
    always_comb begin
        total_s  = asum_q + {{DECIM_LOG2{y_s[YW-1]}}, y_s};
        mtotal_s = msum_q + {{DECIM_LOG2{1'b0}}, bus.AM_in};
        mean_s   = mtotal_s[MW-1:DECIM_LOG2];
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        asum_d   = asum_q;
        msum_d   = msum_q;
        if (frame_start_s) begin
            cnt_d  = cnt_q + CNT_ONE;
            mode_d = bus.mode;
            asum_d = {{DECIM_LOG2{y_s[YW-1]}}, y_s};
            msum_d = {{DECIM_LOG2{1'b0}}, bus.AM_in};
        end else if (bus.sample_en) begin
            cnt_d  = cnt_q + CNT_ONE;
            asum_d = total_s;
            msum_d = mtotal_s;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Frame result: arithmetic shift down, then clamp to the output range.
    always_comb begin
        q_wide_s   = 32'(total_s >>> DECIM_LOG2);
        level_ok_s = (mean_s >= bus.sq_thresh);
        case (saturate(q_wide_s, OUT_WIDTH))
            SAT_HI:   q_sat_s = OUT_MAX;
            SAT_LO:   q_sat_s = OUT_MIN;
            SAT_NONE: q_sat_s = q_wide_s[OUT_WIDTH-1:0];
            default:  q_sat_s = q_wide_s[OUT_WIDTH-1:0];
        endcase
    end

    // Squelch next-state; evaluated only when a frame completes.
    always_comb begin
        sq_state_d = sq_state_q;
        hold_d     = hold_q;
        if (frame_end_s) begin
            case (sq_state_q)
                SQ_CLOSED: begin
                    if (level_ok_s) begin
                        sq_state_d = SQ_OPEN;
                    end else begin
                        sq_state_d = SQ_CLOSED;
                    end
                end
                SQ_OPEN: begin
                    if (level_ok_s) begin
                        sq_state_d = SQ_OPEN;
                    end else begin
                        sq_state_d = SQ_HANG;
                        hold_d     = HOLD_LOAD;
                    end
                end
                SQ_HANG: begin
                    if (level_ok_s) begin
                        sq_state_d = SQ_OPEN;
                    end else if (hold_q == {HW{1'b0}}) begin
                        sq_state_d = SQ_CLOSED;
                    end else begin
                        hold_d     = hold_q - HOLD_ONE;
                    end
                end
                default: begin
                    sq_state_d = SQ_CLOSED;
                    hold_d     = {HW{1'b0}};
                end
            endcase
        end else begin
            sq_state_d = sq_state_q;
        end
    end

    // Output stage: audio gated by the post-update squelch state and mute.
    always_comb begin
        audio_valid_d = frame_end_s;
        audio_out_d   = audio_out_q;
        sq_open_d     = sq_open_q;
        if (frame_end_s) begin
            sq_open_d = (sq_state_d != SQ_CLOSED);
            if (sq_open_d && (mode_q != MODE_MUTE)) begin
                audio_out_d = q_sat_s;
            end else begin
                audio_out_d = {OUT_WIDTH{1'b0}};
            end
        end else begin
            sq_open_d = sq_open_q;
        end
    end

    // Frame counter, mode latch and accumulator registers.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            cnt_q  <= CNT_ZERO;
            mode_q <= MODE_FM;
            asum_q <= {SW{1'b0}};
            msum_q <= {MW{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            asum_q <= asum_d;
            msum_q <= msum_d;
        end
    end

    // Squelch state register.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            sq_state_q <= SQ_CLOSED;
            hold_q     <= {HW{1'b0}};
        end else begin
            sq_state_q <= sq_state_d;
            hold_q     <= hold_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            audio_out_q   <= {OUT_WIDTH{1'b0}};
            audio_valid_q <= 1'b0;
            sq_open_q     <= 1'b0;
        end else begin
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
            sq_open_q     <= sq_open_d;
        end
    end

    assign bus.audio_out    = audio_out_q;
    assign bus.audio_valid  = audio_valid_q;
    assign bus.squelch_open = sq_open_q;
endmodule

// File: tb/tb_demod_audio_post.sv
// Randomized bench for demod_audio_post against a frame-level reference model.
module tb_demod_audio_post;
    import demod_audio_pkg::*;

    localparam int IW = 12;
    localparam int OW = 12;
    localparam int DL = 3;
    localparam int DS = 8;
    localparam int SH = 16;
    localparam int FRAME = 1 << DL;

    logic clk_in = 1'b0;
    logic RST    = 1'b0;

    demod_audio_post_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    demod_audio_post #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .DECIM_LOG2 (DL),
        .DC_SHIFT   (DS),
        .SQ_HOLD    (SH)
    ) dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: frame contents as lists, squelch as a run length.
    longint m_acc;
    longint ys[$];
    longint ams[$];
    int     fmode;
    bit     seen_high;
    int     low_run;
    longint exp_out;
    bit     exp_valid;
    bit     exp_open;
    longint last_audio;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        ys.delete();
        ams.delete();
        fmode = 0;
        seen_high = 1'b0;
        low_run = 0;
        exp_out = 0;
        exp_valid = 1'b0;
        exp_open = 1'b0;
    endtask

    task automatic model_sample();
        longint x, dc, y, tot, msum, q, mean;
        if (ys.size() == 0) fmode = int'(bus.mode);
        case (fmode)
            0: x = longint'($signed(bus.FM_in));
            1: x = longint'($signed(bus.PM_in));
            2: x = longint'(bus.AM_in);
            default: x = 0;
        endcase
        dc = m_acc >>> DS;
        y = x - dc;
        m_acc = m_acc + y;
        ys.push_back(y);
        ams.push_back(longint'(bus.AM_in));
        exp_valid = 1'b0;
        if (ys.size() == FRAME) begin
            tot = 0;
            msum = 0;
            foreach (ys[i]) tot += ys[i];
            foreach (ams[i]) msum += ams[i];
            q = tot >>> DL;
            if (q > 2047) q = 2047;
            if (q < -2048) q = -2048;
            mean = msum / FRAME;
            if (mean >= longint'(bus.sq_thresh)) begin
                seen_high = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
            exp_open = seen_high && (low_run <= SH);
            exp_out = (exp_open && fmode != 3) ? q : 0;
            exp_valid = 1'b1;
            ys.delete();
            ams.delete();
        end
    endtask

    task automatic step(input bit se);
        bus.sample_en = se;
        if (se) model_sample();
        else exp_valid = 1'b0;
        @(posedge clk_in);
        #1;
        check_val("audio_valid", longint'(bus.audio_valid), longint'(exp_valid));
        check_val("audio_out", longint'($signed(bus.audio_out)), exp_out);
        check_val("squelch_open", longint'(bus.squelch_open), longint'(exp_open));
        if (bus.audio_valid) last_audio = longint'($signed(bus.audio_out));
    endtask

    task automatic frame();
        for (int i = 0; i < FRAME; i++) step(1'b1);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check_val("rst_audio_out", longint'($signed(bus.audio_out)), 0);
        check_val("rst_audio_valid", longint'(bus.audio_valid), 0);
        check_val("rst_squelch_open", longint'(bus.squelch_open), 0);
        model_reset();
        step(1'b0);
        step(1'b0);
        RST = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_en = 1'b0;
        bus.mode      = MODE_FM;
        bus.sq_thresh = 12'd0;
        bus.FM_in     = 12'd0;
        bus.PM_in     = 12'd0;
        bus.AM_in     = 12'd0;
        last_audio    = 0;
        model_reset();
        do_reset();

        // Constant FM: DC tracker pulls output from ~100 toward 0.
        bus.FM_in = 12'd100;
        frame();
        check_val("fm_first_in_range", longint'(last_audio >= 97 && last_audio <= 100), 1);
        for (int i = 0; i < 4096 - FRAME; i++) step(1'b1);
        check_val("fm_settled_near_zero", longint'(last_audio >= -1 && last_audio <= 1), 1);

        // Square wave +-500, period 16 samples, aligned to frames.
        do_reset();
        for (int p = 0; p < 24; p++) begin
            bus.FM_in = (p % 2 == 0) ? 12'd500 : 12'hE0C;
            frame();
            if (p >= 2) check_val("square_sign", longint'(last_audio > 0), longint'(p % 2 == 0));
        end

        // Reset mid-frame at cnt=5; next frame needs exactly 8 fresh samples.
        for (int i = 0; i < 5; i++) step(1'b1);
        do_reset();
        for (int i = 0; i < FRAME - 1; i++) step(1'b1);
        check_val("no_valid_before_8", longint'(bus.audio_valid), 0);
        step(1'b1);
        check_val("valid_at_8", longint'(bus.audio_valid), 1);

        // Squelch with hang time.
        do_reset();
        bus.sq_thresh = 12'd200;
        bus.AM_in     = 12'd300;
        bus.FM_in     = 12'd50;
        frame();
        check_val("sq_open_f1", longint'(bus.squelch_open), 1);
        bus.AM_in = 12'd100;
        for (int f = 0; f < SH; f++) frame();
        check_val("sq_hang_held", longint'(bus.squelch_open), 1);
        frame();
        check_val("sq_closed_f17", longint'(bus.squelch_open), 0);
        for (int f = 0; f < 3; f++) begin
            frame();
            check_val("closed_audio_zero", last_audio, 0);
        end

        // Saturation after a long negative run.
        do_reset();
        bus.sq_thresh = 12'd0;
        bus.AM_in     = 12'd0;
        bus.FM_in     = 12'h800;
        for (int i = 0; i < 8192; i++) step(1'b1);
        bus.FM_in = 12'h7FF;
        frame();
        check_val("sat_positive", last_audio, 2047);

        // Mode change mid-frame, then mute.
        do_reset();
        bus.FM_in = 12'd300;
        bus.AM_in = 12'd1000;
        frame();
        for (int i = 0; i < 3; i++) step(1'b1);
        bus.mode = MODE_AM;
        for (int i = 3; i < FRAME; i++) step(1'b1);
        check_val("fm_frame_before_am", longint'(last_audio < 400), 1);
        frame();
        check_val("am_frame_level", longint'(last_audio > 500), 1);
        bus.mode = MODE_MUTE;
        for (int f = 0; f < 3; f++) begin
            frame();
            check_val("mute_valid", longint'(bus.audio_valid), 1);
            check_val("mute_zero", last_audio, 0);
        end

        // Randomized traffic with gaps, mode changes and occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.FM_in = 12'($urandom_range(0, 4095));
            bus.PM_in = 12'($urandom_range(0, 4095));
            bus.AM_in = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) bus.sq_thresh = 12'($urandom_range(0, 3000));
            if ($urandom_range(0, 499) == 0) do_reset();
            else step($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
